// File: rtl/doppler_led_pkg.sv
// Shared types and helpers for the Doppler 4x4 LED matrix scanner.
//   ROWS, COLS   : matrix geometry
//   scan_state_e : per-row scan phase (blanking, lit PWM window, dark remainder)
//   step_cycles  : clk cycles per brightness step within a row window
package doppler_led_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  typedef enum logic [1:0] {
    StBlank,
    StOn,
    StOff
  } scan_state_e;

  function automatic int unsigned step_cycles(input int unsigned row_cycles);
    return row_cycles / 16;
  endfunction

endpackage

// File: rtl/led_row_timer.sv
// Row slot timer for the LED matrix scanner.
// Sequences BLANK -> ON -> OFF for each row and wraps the row index 3 -> 0.
// The state/counter registers describe the cycle currently being executed.
//   clk            : clock
//   rst            : asynchronous active-high reset
//   brightness     : 4-bit PWM level, latched as the BLANK phase ends
//   state          : phase of the current cycle
//   row            : row of the current cycle
//   frame_boundary : high on the first BLANK cycle of row 0
module led_row_timer
  import doppler_led_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 12000,
  parameter int unsigned BLANK_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  brightness,
  output scan_state_e state,
  output logic [1:0]  row,
  output logic        frame_boundary
);

  localparam int unsigned CntW = $clog2(BLANK_CYCLES + ROW_CYCLES);
  localparam int unsigned Step = step_cycles(ROW_CYCLES);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] RowCyc    = CntW'(ROW_CYCLES);
  localparam logic [CntW-1:0] One       = CntW'(1);

  scan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] on_len_q, on_len_d;
  logic [1:0]      row_q, row_d;
  logic [CntW-1:0] on_len_new;

  assign on_len_new = CntW'(brightness) * CntW'(Step);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + One;
    row_d    = row_q;
    on_len_d = on_len_q;
    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          cnt_d    = '0;
          on_len_d = on_len_new;
          // Zero brightness skips ON entirely; OFF then fills the whole window.
          state_d  = (brightness == 4'd0) ? StOff : StOn;
        end
      end
      StOn: begin
        if (cnt_q == on_len_q - One) begin
          cnt_d   = '0;
          state_d = StOff;
        end
      end
      StOff: begin
        // OFF is the remainder of the window, keeping the slot length fixed.
        if (cnt_q == RowCyc - on_len_q - One) begin
          cnt_d   = '0;
          state_d = StBlank;
          row_d   = row_q + 2'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StBlank;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StBlank;
      cnt_q    <= '0;
      on_len_q <= '0;
      row_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      on_len_q <= on_len_d;
      row_q    <= row_d;
    end
  end

  assign state          = state_q;
  assign row            = row_q;
  assign frame_boundary = (state_q == StBlank) && (cnt_q == '0) && (row_q == 2'd0);

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed scan driver for the Doppler 4x4 LED matrix.
// Takes a 16-bit frame over valid/ready into a pending buffer, swaps it into the
// active buffer only at frame boundaries, and scans rows with blanking and PWM.
//   clk, rst    : clock and asynchronous active-high reset
//   frame_data  : bitmap, bit [4*r+c] = row r column c
//   frame_valid : frame_data offered
//   frame_ready : pending buffer empty
//   brightness  : global PWM level 0..15
//   aled        : one-hot row anode enable
//   kled_tri    : column drive enables (1 = drive)
//   row_idx     : row currently in its slot
//   frame_start : pulse on row 0's first BLANK cycle
module led_matrix_scan
  import doppler_led_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 12000,
  parameter int unsigned BLANK_CYCLES = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [3:0]           brightness,
  output logic [ROWS-1:0]      aled,
  output logic [COLS-1:0]      kled_tri,
  output logic [1:0]           row_idx,
  output logic                 frame_start
);

  scan_state_e scan_state;
  logic [1:0]  scan_row;
  logic        frame_boundary;

  led_row_timer #(
    .ROW_CYCLES  (ROW_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .brightness    (brightness),
    .state         (scan_state),
    .row           (scan_row),
    .frame_boundary(frame_boundary)
  );

  logic [ROWS*COLS-1:0] pending_q, pending_d;
  logic [ROWS*COLS-1:0] active_q, active_d;
  logic                 ready_q, ready_d;
  logic [ROWS-1:0]      aled_q, aled_d;
  logic [COLS-1:0]      kled_q, kled_d;
  logic [1:0]           row_idx_q;
  logic                 frame_start_q;
  logic                 accept;

  assign accept = frame_valid & ready_q;

  // Swap and accept are exclusive: accepting needs an empty pending buffer.
  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    ready_d   = ready_q;
    if (frame_boundary && !ready_q) begin
      active_d = pending_q;
      ready_d  = 1'b1;
    end
    if (accept) begin
      pending_d = frame_data;
      ready_d   = 1'b0;
    end
  end

  always_comb begin
    aled_d = '0;
    kled_d = '0;
    if (scan_state == StOn) begin
      aled_d = ROWS'(1) << scan_row;
      kled_d = active_q[{scan_row, 2'b00} +: COLS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      active_q      <= '0;
      ready_q       <= 1'b1;
      aled_q        <= '0;
      kled_q        <= '0;
      row_idx_q     <= 2'd0;
      frame_start_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      active_q      <= active_d;
      ready_q       <= ready_d;
      aled_q        <= aled_d;
      kled_q        <= kled_d;
      row_idx_q     <= scan_row;
      frame_start_q <= frame_boundary;
    end
  end

  assign frame_ready = ready_q;
  assign aled        = aled_q;
  assign kled_tri    = kled_q;
  assign row_idx     = row_idx_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan (ROW_CYCLES=32, BLANK_CYCLES=4).
module tb_led_matrix_scan;

  localparam int unsigned RowCycles   = 32;
  localparam int unsigned BlankCycles = 4;
  localparam int unsigned Step        = 2;
  localparam int unsigned Slot        = 36;
  localparam int unsigned Frame       = 144;

  logic        clk;
  logic        rst;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [3:0]  brightness;
  logic [3:0]  aled;
  logic [3:0]  kled_tri;
  logic [1:0]  row_idx;
  logic        frame_start;

  led_matrix_scan #(
    .ROW_CYCLES  (RowCycles),
    .BLANK_CYCLES(BlankCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .brightness (brightness),
    .aled       (aled),
    .kled_tri   (kled_tri),
    .row_idx    (row_idx),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] aled;
    logic [3:0] kled;
    logic [1:0] row;
    logic       fs;
    logic       ready;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] offer_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc;
  logic [15:0] m_act, m_pend;
  logic        m_full;
  int          m_on;

  task automatic model_reset();
    cyc    = 0;
    m_act  = 16'h0;
    m_pend = 16'h0;
    m_full = 1'b0;
    m_on   = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, push the model's expectation, sample at negedge.
  task automatic step();
    exp_t e;
    exp_t got;
    exp_t act;
    int   pos;
    int   row;
    logic boundary;
    if (offer_q.size() > 0) begin
      frame_valid = 1'b1;
      frame_data  = offer_q[0];
    end else begin
      frame_valid = 1'b0;
      frame_data  = 16'($urandom);
    end
    pos      = cyc % Slot;
    row      = (cyc / Slot) % 4;
    boundary = (pos == 0) && (row == 0);
    if (boundary && m_full) begin
      m_act  = m_pend;
      m_full = 1'b0;
    end else if (frame_valid && !m_full) begin
      m_pend = frame_data;
      m_full = 1'b1;
      void'(offer_q.pop_front());
    end
    if (pos == BlankCycles - 1) m_on = int'(brightness) * Step;
    e.fs    = boundary;
    e.row   = 2'(row);
    e.ready = !m_full;
    e.aled  = 4'h0;
    e.kled  = 4'h0;
    if (pos >= BlankCycles && (pos - BlankCycles) < m_on) begin
      e.aled = 4'(1 << row);
      e.kled = m_act[4*row +: 4];
    end
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    act = {aled, kled_tri, row_idx, frame_start, frame_ready};
    n_checks++;
    if (act !== got) begin
      n_fail++;
      $display("FAIL scan cyc=%0d: got aled=%b kled=%b row=%0d fs=%b rdy=%b, want aled=%b kled=%b row=%0d fs=%b rdy=%b",
               cyc, aled, kled_tri, row_idx, frame_start, frame_ready,
               got.aled, got.kled, got.row, got.fs, got.ready);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_boundary();
    while (cyc % Frame != 0) step();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    frame_valid = 1'b0;
    frame_data  = 16'h0;
    brightness  = 4'd0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({aled, kled_tri, row_idx, frame_start, frame_ready} !== 12'b0000_0000_00_0_1) begin
      n_fail++;
      $display("FAIL reset_values: got aled=%b kled=%b row=%0d fs=%b rdy=%b, want 0 0 0 0 1",
               aled, kled_tri, row_idx, frame_start, frame_ready);
    end
    model_reset();
    rst = 1'b0;
    step();
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL first_frame_start: got %b, want 1", frame_start);
    end
  endtask

  task automatic test_single_pixel();
    brightness = 4'd15;
    offer_q.push_back(16'h0001);
    run_to_boundary();
    run(Frame);
    run(5);
    n_checks++;
    if ({aled, kled_tri} !== 8'h11) begin
      n_fail++;
      $display("FAIL pixel_on: got aled=%b kled=%b, want 0001 0001", aled, kled_tri);
    end
    run(30);
    n_checks++;
    if ({aled, kled_tri} !== 8'h00) begin
      n_fail++;
      $display("FAIL pixel_off_tail: got aled=%b kled=%b, want 0000 0000", aled, kled_tri);
    end
    run_to_boundary();
  endtask

  task automatic test_dark();
    int lit;
    int starts;
    brightness = 4'd0;
    offer_q.push_back(16'hFFFF);
    run(Frame);
    lit    = 0;
    starts = 0;
    for (int i = 0; i < Frame; i++) begin
      step();
      if (aled != 4'h0 || kled_tri != 4'h0) lit++;
      if (frame_start) starts++;
    end
    n_checks++;
    if (lit != 0 || starts != 1) begin
      n_fail++;
      $display("FAIL dark_frame: got lit=%0d starts=%0d, want lit=0 starts=1", lit, starts);
    end
  endtask

  task automatic test_half();
    int on3;
    int starts;
    int lit1;
    brightness = 4'd8;
    offer_q.push_back(16'hF000);
    run(Frame);
    on3    = 0;
    starts = 0;
    for (int i = 0; i < Frame; i++) begin
      step();
      if (row_idx == 2'd3 && aled == 4'b1000 && kled_tri == 4'hF) on3++;
      if (frame_start) starts++;
    end
    n_checks++;
    if (on3 != 16 || starts != 1) begin
      n_fail++;
      $display("FAIL half_row3: got on=%0d starts=%0d, want on=16 starts=1", on3, starts);
    end
    // Change brightness mid-ON of row 0: row 0 keeps 8, row 1 uses 3.
    run(10);
    brightness = 4'd3;
    run(26);
    lit1 = 0;
    for (int i = 0; i < Slot; i++) begin
      step();
      if (aled != 4'h0) lit1++;
    end
    n_checks++;
    if (lit1 != 6) begin
      n_fail++;
      $display("FAIL brightness_next_row: got lit=%0d, want 6", lit1);
    end
    run(Frame - 2 * Slot);
  endtask

  task automatic test_handshake();
    brightness = 4'd15;
    run(20);
    offer_q.push_back(16'hA5A5);
    offer_q.push_back(16'h5A5A);
    step();
    n_checks++;
    if (frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_accept_a: got ready=%b, want 0", frame_ready);
    end
    run(Frame - 22);
    step();
    n_checks++;
    if (frame_ready !== 1'b0 || offer_q.size() != 1) begin
      n_fail++;
      $display("FAIL hs_stall_b: got ready=%b queued=%0d, want ready=0 queued=1",
               frame_ready, offer_q.size());
    end
    step();
    n_checks++;
    if (frame_ready !== 1'b1 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_boundary: got ready=%b fs=%b, want 1 1", frame_ready, frame_start);
    end
    step();
    n_checks++;
    if (frame_ready !== 1'b0 || offer_q.size() != 0) begin
      n_fail++;
      $display("FAIL hs_accept_b: got ready=%b queued=%0d, want ready=0 queued=0",
               frame_ready, offer_q.size());
    end
    run_to_boundary();
    run(Frame);
  endtask

  task automatic test_boundary_accept();
    run_to_boundary();
    run(Frame);
    n_checks++;
    if (frame_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ba_precondition: got ready=%b, want 1", frame_ready);
    end
    offer_q.push_back(16'h0F0F);
    step();
    n_checks++;
    if (frame_ready !== 1'b0 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL ba_accept: got ready=%b fs=%b, want 0 1", frame_ready, frame_start);
    end
    run(2 * Frame - 1);
  endtask

  task automatic test_mid_reset();
    brightness = 4'd15;
    offer_q.push_back(16'h8421);
    run_to_boundary();
    run(Frame);
    offer_q.push_back(16'h1234);
    run(Slot + 5);
    n_checks++;
    if ({aled, kled_tri, frame_ready} !== 9'b0010_0010_0) begin
      n_fail++;
      $display("FAIL mr_before: got aled=%b kled=%b rdy=%b, want 0010 0010 0",
               aled, kled_tri, frame_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({aled, kled_tri, row_idx, frame_start, frame_ready} !== 12'b0000_0000_00_0_1) begin
      n_fail++;
      $display("FAIL mr_async: got aled=%b kled=%b row=%0d fs=%b rdy=%b, want 0 0 0 0 1",
               aled, kled_tri, row_idx, frame_start, frame_ready);
    end
    offer_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    step();
    n_checks++;
    if (frame_start !== 1'b1 || row_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL mr_restart: got fs=%b row=%0d, want 1 0", frame_start, row_idx);
    end
    run(Frame + 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_pixel();
    test_dark();
    test_half();
    test_handshake();
    test_boundary_accept();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
